// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, a one-outstanding-request imem
// handshake, a one-entry skid buffer and the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_f_reg;
  logic [31:0] skid_reg;
  logic [31:0] pc_f_plus4;
  logic        ifid_load;
  logic [31:0] ifid_instr;

  assign pc_f_plus4 = pc_f_reg + 32'd4;
  assign imem_addr  = pc_f_reg;

  // An instruction enters IF/ID only when nothing upstream or downstream
  // blocks it: no redirect, no flush and decode ready to accept.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_instr = imem_rsp_data;
    if (!pc_src_e && !flush_d && !stall_d) begin
      if (state_reg == S_WAIT && imem_rsp_valid) begin
        ifid_load = 1'b1;
      end else if (state_reg == S_HOLD) begin
        ifid_load  = 1'b1;
        ifid_instr = skid_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_BOOT;
      pc_f_reg       <= RESET_PC;
      skid_reg       <= '0;
      imem_req_valid <= 1'b0;
    end else begin
      if (pc_src_e) begin
        pc_f_reg <= pc_target_e;
      end else if (ifid_load) begin
        pc_f_reg <= pc_f_plus4;
      end

      case (state_reg)
        S_BOOT: begin
          state_reg      <= S_REQ;
          imem_req_valid <= 1'b1;
        end

        S_REQ: begin
          if (imem_req_ready) begin
            // A redirect that coincides with acceptance leaves a stale
            // response in flight that must be swallowed.
            state_reg      <= pc_src_e ? S_DRAIN : S_WAIT;
            imem_req_valid <= 1'b0;
          end else begin
            state_reg      <= S_REQ;
            imem_req_valid <= 1'b1;
          end
        end

        S_WAIT: begin
          if (pc_src_e) begin
            if (imem_rsp_valid) begin
              state_reg      <= S_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              state_reg      <= S_DRAIN;
              imem_req_valid <= 1'b0;
            end
          end else if (imem_rsp_valid) begin
            if (flush_d) begin
              state_reg      <= S_REQ;
              imem_req_valid <= 1'b1;
            end else if (stall_d) begin
              skid_reg       <= imem_rsp_data;
              state_reg      <= S_HOLD;
              imem_req_valid <= 1'b0;
            end else begin
              state_reg      <= S_REQ;
              imem_req_valid <= 1'b1;
            end
          end else begin
            state_reg      <= S_WAIT;
            imem_req_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          // Leaving HOLD either consumes the buffer or abandons it and
          // re-fetches from the (possibly redirected) PC.
          if (pc_src_e || flush_d || !stall_d) begin
            state_reg      <= S_REQ;
            imem_req_valid <= 1'b1;
          end else begin
            state_reg      <= S_HOLD;
            imem_req_valid <= 1'b0;
          end
        end

        S_DRAIN: begin
          if (imem_rsp_valid) begin
            state_reg      <= S_REQ;
            imem_req_valid <= 1'b1;
          end else begin
            state_reg      <= S_DRAIN;
            imem_req_valid <= 1'b0;
          end
        end

        default: begin
          state_reg      <= S_BOOT;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: flush beats stall, stall holds, otherwise load or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (stall_d) begin
      instr_d    <= instr_d;
      pc_d       <= pc_d;
      pc_plus4_d <= pc_plus4_d;
      valid_d    <= valid_d;
    end else if (ifid_load) begin
      instr_d    <= ifid_instr;
      pc_d       <= pc_f_reg;
      pc_plus4_d <= pc_f_plus4;
      valid_d    <= 1'b1;
    end else begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural instruction memory of
// programmable response latency.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;

  int n_tests = 0;
  int n_fail  = 0;

  if_stage #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .pc_src_e       (pc_src_e),
    .pc_target_e    (pc_target_e),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: {addr[23:0], 8'h13}, with one special word at 0x108.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0108) return 32'h00A0_0093;
    return {a[23:0], 8'h13};
  endfunction

  int          acc_cnt  = 0;
  int          acc_seen = 0;
  logic [31:0] acc_addr = '0;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr = '0;
  int          lat_cnt  = 0;
  int          mem_lat  = 1;

  always @(posedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      acc_addr = imem_addr;
      acc_cnt  = acc_cnt + 1;
    end
  end

  initial imem_rsp_data = '0;
  always @(negedge clk or negedge rst_n) begin
    imem_rsp_valid = 1'b0;
    if (!rst_n) begin
      pend     = 1'b0;
      acc_seen = acc_cnt;
    end else begin
      if (acc_cnt != acc_seen) begin
        acc_seen  = acc_cnt;
        pend      = 1'b1;
        pend_addr = acc_addr;
        lat_cnt   = mem_lat - 1;
      end
      if (pend) begin
        if (lat_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr);
          pend           = 1'b0;
        end else begin
          lat_cnt = lat_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] ins,
                            input logic [31:0] pc, input logic [31:0] pc4,
                            input logic v);
    check({tag, ".instr"}, instr_d, ins);
    check({tag, ".pc"}, pc_d, pc);
    check({tag, ".pc4"}, pc_plus4_d, pc4);
    check({tag, ".valid"}, {31'd0, valid_d}, {31'd0, v});
  endtask

  task automatic wait_load(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (valid_d) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b1; imem_req_ready = 1'b1;
    stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = '0;
    #1 rst_n = 1'b0;
    #1;
    check_ifid("reset", NOP, 32'h0, 32'h0, 1'b0);
    check("reset.req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("reset.addr", imem_addr, 32'h100);
    step(); step();
    rst_n = 1'b1;

    // Boot cycle, then first request and its load.
    step();
    check("boot.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("boot.addr", imem_addr, 32'h100);
    step();
    check("wait.req_valid", {31'd0, imem_req_valid}, 32'd0);
    step();
    check_ifid("first", 32'h0001_0013, 32'h100, 32'h104, 1'b1);
    check("first.next_addr", imem_addr, 32'h104);

    // Memory not ready for 5 cycles.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("notready%0d.req_valid", i), {31'd0, imem_req_valid}, 32'd1);
      check($sformatf("notready%0d.addr", i), imem_addr, 32'h104);
      check($sformatf("notready%0d.valid", i), {31'd0, valid_d}, 32'd0);
      check($sformatf("notready%0d.pc", i), pc_d, 32'h100);
    end
    imem_req_ready = 1'b1;
    step();
    step();
    check_ifid("after_ready", 32'h0001_0413, 32'h104, 32'h108, 1'b1);

    // Stall across the arrival of the 0x108 response.
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid($sformatf("stall%0d", i), 32'h0001_0413, 32'h104, 32'h108, 1'b1);
      if (i == 1) check("hold.req_valid", {31'd0, imem_req_valid}, 32'd0);
    end
    stall_d = 1'b0;
    step();
    check_ifid("unstall", 32'h00A0_0093, 32'h108, 32'h10C, 1'b1);
    check("unstall.addr", imem_addr, 32'h10C);
    check("unstall.req_valid", {31'd0, imem_req_valid}, 32'd1);

    // Redirect while WAIT has no response yet: stale response is drained.
    mem_lat = 2;
    step();
    pc_src_e = 1'b1; pc_target_e = 32'h200;
    step();
    pc_src_e = 1'b0;
    check("redir.addr", imem_addr, 32'h200);
    check("redir.req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("redir.valid", {31'd0, valid_d}, 32'd0);
    step();
    check("drain.valid", {31'd0, valid_d}, 32'd0);
    check("drain.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("drain.addr", imem_addr, 32'h200);
    wait_load(10, ok);
    check("redir.loaded", {31'd0, ok}, 32'd1);
    check_ifid("redir_load", 32'h0002_0013, 32'h200, 32'h204, 1'b1);
    mem_lat = 1;

    // Flush with stall: bubble wins, pc fields held.
    stall_d = 1'b1; flush_d = 1'b1;
    step();
    check_ifid("flush", NOP, 32'h200, 32'h204, 1'b0);
    // Flush coinciding with a response: dropped, same PC re-fetched.
    stall_d = 1'b0;
    step();
    flush_d = 1'b0;
    check("flushrsp.valid", {31'd0, valid_d}, 32'd0);
    check("flushrsp.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("flushrsp.addr", imem_addr, 32'h204);
    step(); step();
    check_ifid("refetch", 32'h0002_0413, 32'h204, 32'h208, 1'b1);

    // Redirect during an unaccepted request retargets it; then wrap.
    imem_req_ready = 1'b0;
    step();
    pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    step();
    pc_src_e = 1'b0;
    check("retarget.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("retarget.addr", imem_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    step(); step();
    check_ifid("wrap", 32'hFFFF_FC13, 32'hFFFF_FFFC, 32'h0, 1'b1);
    check("wrap.next_addr", imem_addr, 32'h0);

    // Asynchronous reset while WAIT is outstanding.
    mem_lat = 3;
    step();
    check("prereset.req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst_n = 1'b0;
    #2;
    check_ifid("async_rst", NOP, 32'h0, 32'h0, 1'b0);
    check("async_rst.req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("async_rst.addr", imem_addr, 32'h100);
    mem_lat = 1;
    step();
    rst_n = 1'b1;
    step();
    check("reboot.req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("reboot.addr", imem_addr, 32'h100);
    step(); step();
    check_ifid("reboot", 32'h0001_0013, 32'h100, 32'h104, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core. Holds the fetch PC and issues one outstanding request at a time to instruction memory over a valid/ready request channel with variable-latency responses.
- Owns the IF/ID pipeline register that feeds the decode stage (main decoder, immediate extender, register file).
- Handles decode stall, decode flush and execute-stage branch/jump redirect, including discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction placed in IF/ID on reset, flush or bubble (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  fetch address (= pc_f).
- imem_rsp_valid  input  1  response data valid; exactly one per accepted request, never in the same cycle as its acceptance.
- imem_rsp_data  input  32  instruction word.
- stall_d  input  1  hazard unit: hold IF/ID and fetch progress.
- flush_d  input  1  hazard unit: clear IF/ID.
- pc_src_e  input  1  execute redirect (taken branch or jal).
- pc_target_e  input  32  redirect target.
- instr_d  output  32  IF/ID instruction to decoder.
- pc_d  output  32  IF/ID PC.
- pc_plus4_d  output  32  IF/ID PC+4 (jal link value).
- valid_d  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, while rst_n=0): pc_f=RESET_PC, state=BOOT, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, imem_req_valid=0. Reset mid-transaction abandons any outstanding request; memory is reset by the same rst_n.
- States:
  - BOOT: one idle cycle after reset release, then REQ.
  - REQ: imem_req_valid=1, imem_addr=pc_f. On imem_req_ready, go to WAIT.
  - WAIT: request outstanding.
  - HOLD: response captured in the skid buffer while decode is stalled.
  - DRAIN: one stale response is outstanding and must be discarded.
- imem_req_valid=1 only in REQ. The address stays stable until accepted, except on a redirect.
- WAIT with imem_rsp_valid:
  - If stall_d=0: load IF/ID with instr_d=rsp_data, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1; set pc_f<=pc_f+4; go to REQ.
  - If stall_d=1: capture rsp_data in the skid buffer; go to HOLD.
- HOLD: on the first cycle with stall_d=0, load IF/ID from the buffer (same fields as above), set pc_f<=pc_f+4, go to REQ.
- When stall_d=0 and no instruction is loaded this cycle, IF/ID takes a bubble: valid_d=0, instr_d=NOP_INSTR; pc_d and pc_plus4_d keep their values.
- stall_d=1: IF/ID holds all fields. The FSM may still issue a request and wait, but never loads IF/ID.
- flush_d=1: IF/ID loads the bubble regardless of stall_d. A response arriving in the same cycle without pc_src_e is discarded, pc_f is unchanged, and the FSM goes to REQ (re-fetch same PC).
- pc_src_e=1 has priority over stall_d and over normal advance. It always sets pc_f<=pc_target_e and discards the skid buffer. Next state depends on the current state:
  - REQ accepted this cycle: DRAIN.
  - REQ not accepted: REQ (the request retargets next cycle).
  - WAIT without rsp_valid: DRAIN.
  - WAIT with rsp_valid: REQ (response dropped).
  - HOLD: REQ.
  - DRAIN: stays DRAIN until its response arrives.
- DRAIN: on imem_rsp_valid, drop the data and go to REQ. IF/ID is not loaded from a drained response.
- Arithmetic: all PC adds are unsigned 32-bit and wrap, so 32'hFFFF_FFFC+4 = 0. Alignment is not checked.
- Throughput: with single-cycle-ready memory and 1-cycle response latency, one instruction every 2 cycles. Maximum latency from acceptance to valid_d is response latency + 1 cycle.

Test Plan:
- Reset with RESET_PC=32'h100 and memory ready with 1-cycle latency. Expect: req in the 2nd cycle after release with addr 0x100; instr_d/pc_d=0x100/pc_plus4_d=0x104/valid_d=1; next addr 0x104.
- imem_req_ready held low 5 cycles. Expect: imem_req_valid=1 and imem_addr constant 0x104 throughout; no IF/ID change except bubbles.
- stall_d=1 when the response arrives (data 32'h00A00093), held 3 cycles. Expect: IF/ID unchanged during the stall; on release it loads 32'h00A00093 with correct pc_d; next addr = pc+4.
- pc_src_e=1, pc_target_e=32'h200 while in WAIT. Expect: next response is dropped (valid_d stays 0), next request addr=0x200, instruction from 0x200 reaches IF/ID.
- flush_d=1 with valid_d=1 and stall_d=1. Expect: instr_d=32'h0000_0013, valid_d=0 next cycle.
- pc_f=32'hFFFF_FFFC fetch completes. Expect: pc_plus4_d=0, next imem_addr=0. Also assert rst_n low while in WAIT: outputs take reset values immediately with no clock edge.
